// File: rtl/alu_pipe.sv
// alu_pipe: fixed-latency integer ALU / multiplier with elastic stage registers.
// Plain ALU ops resolve in stage 0 and ride the pipe. Multiplies split the
// partial-product sum across the stages, C extended-opb bits per stage.
module alu_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             squash,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_opa,
   input  logic [XLEN-1:0]  in_opb,
   input  logic [3:0]       in_func,
   input  logic             in_is_mul,
   input  logic [1:0]       in_mul_func,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_grant,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);
   localparam int W2 = 2 * XLEN;
   localparam int C  = W2 / STAGES;
   localparam int SH = $clog2(XLEN);
   // stages that carry multiply state forward (all but the last one)
   localparam int MN = (STAGES > 1) ? STAGES - 1 : 1;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // sum of partial products of a with one C-bit slice of b, weighted by slice k
   function automatic logic [W2-1:0] pp(input logic [W2-1:0] a, input logic [C-1:0] b, input int k);
      logic [W2-1:0] bz;
      bz = W2'(b);
      return (a * bz) << (k * C);
   endfunction

   // MUL keeps the low half, every MULH flavour the high half
   function automatic logic [XLEN-1:0] pick(input logic [W2-1:0] acc, input logic is_mul, input logic [1:0] mf);
      return (is_mul && mf != 2'd0) ? acc[W2-1:XLEN] : acc[XLEN-1:0];
   endfunction

   logic [STAGES-1:0]             vld;
   logic [STAGES-1:0][TAG_W-1:0]  tag;
   logic [STAGES-1:0]             adv;
   logic [MN-1:0]                 m_mul;
   logic [MN-1:0][1:0]            m_mf;
   logic [MN-1:0][W2-1:0]         m_a, m_b, m_acc;
   logic [XLEN-1:0]               res_q;

   logic                          a_sx, b_sx;
   logic [W2-1:0]                 a_x, b_x;
   logic [SH-1:0]                 sh;
   logic [XLEN-1:0]               alu_r;
   logic [STAGES-1:0][W2-1:0]     acc_n;

   // index k of each chain is what stage k loads: index 0 is the input port
   logic [STAGES:0]               v_chain;
   logic [STAGES:0][TAG_W-1:0]    t_chain;
   logic [MN:0]                   mul_chain;
   logic [MN:0][1:0]              mf_chain;
   logic [MN:0][W2-1:0]           a_chain, b_chain;
   logic                          unused_ok;

   assign v_chain   = {vld, in_valid};
   assign t_chain   = {tag, in_tag};
   assign mul_chain = {m_mul, in_is_mul};
   assign mf_chain  = {m_mf, in_mul_func};
   assign a_chain   = {m_a, a_x};
   assign b_chain   = {m_b, b_x};
   assign unused_ok = ^{v_chain[STAGES], t_chain[STAGES], a_chain[MN], b_chain[MN], m_acc};

   // MULH sign-extends both, MULHSU only opa, MUL/MULHU neither
   assign a_sx = (in_mul_func == 2'd1) || (in_mul_func == 2'd2);
   assign b_sx = (in_mul_func == 2'd1);
   assign a_x  = {{XLEN{a_sx & in_opa[XLEN-1]}}, in_opa};
   assign b_x  = {{XLEN{b_sx & in_opb[XLEN-1]}}, in_opb};
   assign sh   = in_opb[SH-1:0];

   // single-cycle ALU for the non-multiply ops
   always_comb begin
      alu_r = '0;
      case (in_func)
         ALU_ADD:  alu_r = in_opa + in_opb;
         ALU_SUB:  alu_r = in_opa - in_opb;
         ALU_AND:  alu_r = in_opa & in_opb;
         ALU_SLT:  alu_r = {{(XLEN-1){1'b0}}, $signed(in_opa) < $signed(in_opb)};
         ALU_SLTU: alu_r = {{(XLEN-1){1'b0}}, in_opa < in_opb};
         ALU_OR:   alu_r = in_opa | in_opb;
         ALU_XOR:  alu_r = in_opa ^ in_opb;
         ALU_SRL:  alu_r = in_opa >> sh;
         ALU_SLL:  alu_r = in_opa << sh;
         ALU_SRA:  alu_r = $unsigned($signed(in_opa) >>> sh);
         default:  alu_r = '0;
      endcase
   end

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_st
         // a stage only stalls when it and every stage ahead are full and the CDB refuses
         assign adv[k] = ~((&vld[STAGES-1:k]) & ~out_grant);
         if (k == 0) begin : g_first
            assign acc_n[k] = mul_chain[0] ? pp(a_chain[0], b_chain[0][C-1:0], 0)
                                           : {{XLEN{1'b0}}, alu_r};
         end else begin : g_rest
            assign acc_n[k] = mul_chain[k] ? m_acc[k-1] + pp(a_chain[k], b_chain[k][k*C +: C], k)
                                           : m_acc[k-1];
         end
      end
   endgenerate

   assign in_ready   = ~reset & adv[0];
   assign out_valid  = vld[STAGES-1];
   assign out_tag    = tag[STAGES-1];
   assign out_result = res_q;

   // valid bits and tags move forward on advance; squash empties every stage
   always_ff @(posedge clock) begin
      if (reset) begin
         vld <= '0;
         tag <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (squash) begin
               vld[i] <= 1'b0;
            end else if (adv[i]) begin
               vld[i] <= v_chain[i];
               tag[i] <= t_chain[i];
            end
         end
      end
   end

   // multiply operands and running accumulator for every stage but the last
   always_ff @(posedge clock) begin
      if (reset) begin
         m_mul <= '0;
         m_mf  <= '0;
         m_a   <= '0;
         m_b   <= '0;
         m_acc <= '0;
      end else if (!squash) begin
         for (int i = 0; i < STAGES - 1; i++) begin
            if (adv[i]) begin
               m_mul[i] <= mul_chain[i];
               m_mf[i]  <= mf_chain[i];
               m_a[i]   <= a_chain[i];
               m_b[i]   <= b_chain[i];
               m_acc[i] <= acc_n[i];
            end
         end
      end
   end

   // last stage stores the already-selected result so the output is a plain register
   always_ff @(posedge clock) begin
      if (reset) begin
         res_q <= '0;
      end else if (!squash && adv[STAGES-1]) begin
         res_q <= pick(acc_n[STAGES-1], mul_chain[STAGES-1], mf_chain[STAGES-1]);
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_alu_pipe;
   localparam int S = 4;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                          OR_ = 4'd5, XOR_ = 4'd6, SRL = 4'd7, SLL = 4'd8, SRA = 4'd9;

   logic        clock = 1'b0;
   logic        reset, squash, in_valid, in_ready, in_is_mul, out_valid, out_grant;
   logic [31:0] in_opa, in_opb, out_result;
   logic [3:0]  in_func;
   logic [1:0]  in_mul_func;
   logic [5:0]  in_tag, out_tag;

   logic        s_valid, s_ready, s_out_valid;
   logic [31:0] s_opa, s_opb, s_out_result;
   logic [3:0]  s_func;
   logic [5:0]  s_tag, s_out_tag;

   alu_pipe #(.XLEN(32), .STAGES(S), .TAG_W(6)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .in_valid(in_valid), .in_ready(in_ready), .in_opa(in_opa), .in_opb(in_opb),
      .in_func(in_func), .in_is_mul(in_is_mul), .in_mul_func(in_mul_func), .in_tag(in_tag),
      .out_valid(out_valid), .out_grant(out_grant), .out_result(out_result), .out_tag(out_tag));

   alu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(6)) dut1 (
      .clock(clock), .reset(reset), .squash(1'b0),
      .in_valid(s_valid), .in_ready(s_ready), .in_opa(s_opa), .in_opb(s_opb),
      .in_func(s_func), .in_is_mul(1'b0), .in_mul_func(2'b00), .in_tag(s_tag),
      .out_valid(s_out_valid), .out_grant(1'b1), .out_result(s_out_result), .out_tag(s_out_tag));

   always #5 clock = ~clock;

   int checks = 0, errors = 0, cyc = 0, last_dep = -100;
   bit started = 0;

   typedef struct { logic [31:0] res; logic [5:0] tag; int t; } item_t;
   item_t q[$];

   logic [31:0] ma [4] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] mb [4] = '{32'h00000002, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] me [4] = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
   logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

   // architectural result of one op, straight from the RV32 definitions
   function automatic logic [31:0] ref_calc(logic [3:0] f, logic m, logic [1:0] mf, logic [31:0] a, logic [31:0] b);
      longint pa, pb, p;
      logic [4:0] sh;
      sh = b[4:0];
      if (m) begin
         pa = (mf == 2'd1 || mf == 2'd2) ? longint'($signed(a)) : longint'({32'd0, a});
         pb = (mf == 2'd1) ? longint'($signed(b)) : longint'({32'd0, b});
         p  = pa * pb;
         return (mf == 2'd0) ? p[31:0] : p[63:32];
      end
      case (f)
         ADD:  return a + b;
         SUB:  return a - b;
         AND_: return a & b;
         SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLTU: return (a < b) ? 32'd1 : 32'd0;
         OR_:  return a | b;
         XOR_: return a ^ b;
         SRL:  return a >> sh;
         SLL:  return a << sh;
         SRA:  return 32'($signed(a) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   // head of the queue is on the output once its latency has elapsed and its predecessor left
   function automatic bit front_here(int n);
      int arr;
      if (q.size() == 0) return 1'b0;
      arr = (q[0].t + S > last_dep + 1) ? q[0].t + S : last_dep + 1;
      return arr <= n;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   // model update on each edge from the inputs of the cycle that just ended
   always @(posedge clock) begin : model
      bit rdy;
      if (reset || squash) begin
         q.delete();
         last_dep = -100;
      end else begin
         rdy = !(q.size() == S && !out_grant);
         if (out_grant && front_here(cyc)) begin
            q.delete(0);
            last_dep = cyc;
         end
         if (in_valid && rdy)
            q.push_back('{res: ref_calc(in_func, in_is_mul, in_mul_func, in_opa, in_opb), tag: in_tag, t: cyc});
      end
      cyc++;
   end

   // every-cycle comparison against the model
   always @(negedge clock) begin : compare
      bit ev;
      if (started) begin
         ev = front_here(cyc);
         chk("in_ready", in_ready, {31'd0, !reset && !(q.size() == S && !out_grant)});
         chk("out_valid", out_valid, {31'd0, ev});
         if (ev) begin
            chk("out_result", out_result, q[0].res);
            chk("out_tag", out_tag, q[0].tag);
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drive(bit v, logic [3:0] f, bit m, logic [1:0] mf, logic [31:0] a, logic [31:0] b, logic [5:0] t);
      in_valid = v; in_func = f; in_is_mul = m; in_mul_func = mf; in_opa = a; in_opb = b; in_tag = t;
   endtask

   initial begin
      reset = 1'b1; squash = 1'b0; out_grant = 1'b0;
      drive(0, ADD, 0, 0, 0, 0, 0);
      s_valid = 1'b0; s_opa = '0; s_opb = '0; s_func = ADD; s_tag = '0;

      // pin the model to hand-computed values
      chk("pin_add", ref_calc(ADD, 0, 0, 5, 7), 32'd12);
      chk("pin_sub", ref_calc(SUB, 0, 0, 3, 5), 32'hFFFFFFFE);
      chk("pin_sra", ref_calc(SRA, 0, 0, 32'h80000000, 31), 32'hFFFFFFFF);
      chk("pin_mulhsu", ref_calc(ADD, 1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);

      tick; started = 1;
      tick; tick;
      #2;
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", out_result, 0);
      chk("rst_tag", out_tag, 0);

      // single ADD, latency S
      tick; reset = 1'b0; out_grant = 1'b1;
      drive(1, ADD, 0, 0, 5, 7, 3);
      #2 chk("ready_after_rst", in_ready, 1);
      tick; in_valid = 1'b0;
      tick; tick;
      #2 chk("lat_early", out_valid, 0);
      tick;
      #2;
      chk("lat_valid", out_valid, 1);
      chk("lat_result", out_result, 12);
      chk("lat_tag", out_tag, 3);
      tick;

      // back-to-back multiplies
      for (int i = 0; i < 4; i++) begin
         drive(1, ADD, 1, 2'(i), ma[i], mb[i], 6'(10 + i));
         tick;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick;
         #2;
         chk("mul_valid", out_valid, 1);
         chk("mul_result", out_result, me[i]);
         chk("mul_tag", out_tag, 32'(10 + i));
      end
      tick; tick;

      // fill with no grant, then drain exactly one
      out_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, ADD, 0, 0, 32'(100 + i), 32'(i), 6'(20 + i));
         tick;
      end
      in_valid = 1'b0;
      #2;
      chk("full_ready", in_ready, 0);
      chk("hold_result", out_result, 100);
      chk("hold_tag", out_tag, 20);
      tick;
      #2 chk("hold_result2", out_result, 100);
      tick; out_grant = 1'b1;
      #2 chk("ready_on_grant", in_ready, 1);
      tick; out_grant = 1'b0;
      #2;
      chk("drain_valid", out_valid, 1);
      chk("drain_result", out_result, 102);
      chk("drain_tag", out_tag, 21);
      chk("drain_ready", in_ready, 1);
      out_grant = 1'b1;
      repeat (5) tick;

      // squash with three in flight, new op right after
      drive(1, ADD, 0, 0, 10, 20, 30); tick;
      drive(1, SUB, 0, 0, 9, 4, 31);   tick;
      drive(1, XOR_, 0, 0, 6, 3, 32); squash = 1'b1; tick;
      squash = 1'b0;
      drive(1, ADD, 0, 0, 1, 2, 40);
      #2 chk("sq_quiet", out_valid, 0);
      tick; in_valid = 1'b0;
      #2 chk("sq_quiet", out_valid, 0);
      tick;
      #2 chk("sq_quiet", out_valid, 0);
      tick;
      #2 chk("sq_quiet", out_valid, 0);
      tick;
      #2;
      chk("sq_new_valid", out_valid, 1);
      chk("sq_new_result", out_result, 3);
      chk("sq_new_tag", out_tag, 40);
      tick; tick;

      // reset with two ops in flight
      drive(1, ADD, 0, 0, 7, 7, 50); tick;
      drive(1, ADD, 0, 0, 8, 8, 51); tick;
      in_valid = 1'b0; reset = 1'b1; tick;
      reset = 1'b0;
      #2;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_valid", out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         #2 chk("post_rst_valid", out_valid, 0);
      end

      // single-stage instance
      tick;
      s_valid = 1'b1; s_func = SRA; s_opa = 32'h80000000; s_opb = 32'd31; s_tag = 6'd5;
      #2 chk("s1_idle", s_out_valid, 0);
      tick;
      s_func = SLT; s_opa = 32'hFFFFFFFF; s_opb = 32'd1; s_tag = 6'd6;
      #2;
      chk("s1_sra_valid", s_out_valid, 1);
      chk("s1_sra_result", s_out_result, 32'hFFFFFFFF);
      chk("s1_sra_tag", s_out_tag, 5);
      tick; s_valid = 1'b0;
      #2;
      chk("s1_slt_valid", s_out_valid, 1);
      chk("s1_slt_result", s_out_result, 1);
      chk("s1_slt_tag", s_out_tag, 6);
      tick;
      #2 chk("s1_drained", s_out_valid, 0);

      // random traffic against the model
      for (int n = 0; n < 800; n++) begin
         tick;
         reset     = ($urandom_range(0, 149) == 0);
         squash    = ($urandom_range(0, 39) == 0);
         out_grant = ($urandom_range(0, 2) != 0);
         drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), $urandom_range(0, 3) == 0,
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom(),
               ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom(),
               6'($urandom_range(0, 63)));
      end
      tick;
      reset = 1'b0; squash = 1'b0; in_valid = 1'b0;
      tick; tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; legal values are 1..2*XLEN where (2*XLEN) % STAGES == 0.
REQ-003 Parameter TAG_W, default 6: width of the destination physical-register tag.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 squash  input  1  flush request; kills every in-flight op.
REQ-007 in_valid  input  1  an op is offered this cycle.
REQ-008 in_ready  output  1  the unit accepts the offered op this cycle.
REQ-009 in_opa, in_opb  input  XLEN each  operands, already selected upstream.
REQ-010 in_func  input  4  shared ALU_FUNC code: ALU_ADD, SUB, AND, SLT, SLTU, OR, XOR, SRL, SLL or SRA.
REQ-011 in_is_mul  input  1  the op is a multiply, and in_func is ignored.
REQ-012 in_mul_func  input  2  multiply selector: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-013 in_tag  input  TAG_W  destination register tag.
REQ-014 out_valid  output  1  a result is presented to the CDB.
REQ-015 out_grant  input  1  the CDB takes the result this cycle.
REQ-016 out_result  output  XLEN  result value.
REQ-017 out_tag  output  TAG_W  tag of the result.

Function
REQ-018 An op is accepted on a cycle when in_valid and in_ready are both high and squash is low.
REQ-019 The unit shall hold STAGES stage registers, each with its own valid bit; out_valid, out_result and out_tag come straight from the last stage's registers.
REQ-020 A stage advances when the next stage is empty or is itself advancing; the last stage advances when out_grant is high or it is empty.
REQ-021 in_ready is high exactly when stage 0 can advance, and in_ready is combinational from out_grant and the valid bits.
REQ-022 Bubbles collapse: an empty stage shall be filled even while later stages are stalled.
REQ-023 A stalled stage shall hold its contents unchanged, and out_valid, out_result and out_tag shall stay stable while out_valid is high and out_grant is low.
REQ-024 Latency with no stall: an op accepted at cycle t appears with out_valid high at cycle t+STAGES.
REQ-025 Throughput: with out_grant held high, the unit accepts one op per cycle.
REQ-026 Ops leave the unit in acceptance order.
REQ-027 Non-multiply ops compute in stage 0 with RV32 semantics; shift amounts use opb[$clog2(XLEN)-1:0]; SLT and SLTU zero-extend a 1-bit result; the result then passes through the later stages unchanged.
REQ-028 Multiply: stage 0 extends opa and opb to 2*XLEN bits.
REQ-029 The extension is signed for both operands for MULH, signed opa with unsigned opb for MULHSU, and unsigned for both for MUL and MULHU.
REQ-030 Each stage k adds into a 2*XLEN accumulator the partial products for extended-opb bits [k*C +: C], where C = 2*XLEN/STAGES.
REQ-031 Accumulation is modulo 2^(2*XLEN).
REQ-032 MUL returns accumulator bits [XLEN-1:0]; MULH, MULHSU and MULHU return bits [2*XLEN-1:XLEN].
REQ-033 On a cycle with squash high, every valid bit shall clear at the next edge, in_valid on that cycle is ignored, and out_grant on that cycle is still honoured by the consumer.
REQ-034 If squash and a grant or an acceptance fall on the same cycle, squash wins for all internal state.

Reset
REQ-035 While reset is high, every stage valid bit, out_valid, out_result and out_tag shall be 0 at the next edge.
REQ-036 While reset is high, in_ready shall be low; in_ready shall be high on the first cycle after reset deasserts.
REQ-037 Reset asserted mid-operation discards all in-flight ops, and no result from before reset ever appears on the output.
REQ-038 Reset takes priority over squash and over acceptance.

Verification
REQ-039 Setup for REQ-040 to REQ-043: STAGES=4, XLEN=32.
REQ-040 Accept ADD 5+7 with tag 3 at cycle 0 and hold out_grant=1 -> out_valid at cycle 4, result 12, tag 3.
REQ-041 Back-to-back MUL 0xFFFFFFFF*2, MULH 0x80000000*0x80000000, MULHSU 0xFFFFFFFF*0xFFFFFFFF, MULHU 0xFFFFFFFF*0xFFFFFFFF -> results 0xFFFFFFFE, 0x40000000, 0xFFFFFFFF, 0xFFFFFFFE on consecutive cycles 4 to 7.
REQ-042 Fill 4 ops with out_grant=0 -> in_ready drops, the output stays stable on the first op; raise out_grant for 1 cycle -> exactly one op drains, in_ready rises, order is preserved.
REQ-043 Accept 3 ops, assert squash at cycle 2 alongside in_valid -> no out_valid ever appears for those ops, and a new op accepted at cycle 3 appears at cycle 7.
REQ-044 With STAGES=1: SRA 0x80000000 by 31 -> 0xFFFFFFFF and SLT -1<1 -> 1, each with 1-cycle latency.
REQ-045 Reset at cycle 2 with 2 ops in flight -> out_valid stays 0 at cycles 3 to 6, and in_ready is high the cycle after reset deasserts.
